// File: rtl/norm_accum_pkg.sv
// Shared types for the norm_accum reduction engine: reduction modes, FSM states
// and the saturation classifier used by the accumulator stage.
package norm_accum_pkg;

    typedef enum logic [1:0] {
        SQ     = 2'b00,
        ABS    = 2'b01,
        SUM    = 2'b10,
        MAXABS = 2'b11
    } mode_e;

    typedef logic [1:0] state_e;
    localparam state_e RUN   = 2'd0;
    localparam state_e DRAIN = 2'd1;
    localparam state_e DONE  = 2'd2;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_MAX  = 2'd1,
        SAT_MIN  = 2'd2
    } sat_e;

    // A one-bit-wider sum is in range iff its top two bits agree.
    function automatic sat_e saturate(input logic ext_msb, input logic msb);
        sat_e s;
        if (ext_msb == msb)
            s = SAT_NONE;
        else if (ext_msb)
            s = SAT_MIN;
        else
            s = SAT_MAX;
        return s;
    endfunction

endpackage

// File: rtl/norm_accum_mem.sv
// Single-port element RAM: synchronous write, registered read-first output,
// so read data always reflects memory contents before a same-cycle write.
module norm_accum_mem
    import norm_accum_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 27
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/norm_accum_pipe.sv
// Pipelined array-reduction engine: issues one RAM element per cycle over
// [lo, hi), forms a per-mode term and accumulates with sticky saturation.
module norm_accum_pipe
    import norm_accum_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              r_enable,
    input  logic [ADDR_W-1:0] init_lo,
    input  logic [ADDR_W:0]   init_hi,
    input  logic [ACC_W-1:0]  init_acc,
    input  logic [1:0]        init_mode,
    input  logic              controlArr,
    input  logic              controlArrWEnable_a,
    input  logic [ADDR_W-1:0] controlArrAddr_a,
    input  logic [DATA_W-1:0] controlArrWData_a,
    output logic [DATA_W-1:0] controlArrRData_a,
    output logic              w_enable,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e                   state;
    mode_e                    mode_q;
    logic [ADDR_W:0]          idx;
    logic [ADDR_W:0]          hi_q;
    logic [ADDR_W:0]          hi_clamped;
    logic                     s0_valid;
    logic                     s1_valid;
    logic                     s2_valid;
    logic signed [DATA_W-1:0] s1_data;
    logic signed [ACC_W:0]    s2_term;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    sum_ext;
    logic signed [ACC_W:0]    term;
    logic [DATA_W-1:0]        abs_x;
    logic [2*DATA_W-1:0]      sq_x;
    logic [DATA_W-1:0]        ram_rdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic                     issue;
    logic                     any_valid;
    sat_e                     sat;

    // The host owns the RAM port whenever controlArr is high; the engine simply skips issuing.
    always_comb begin
        issue      = (state == RUN) && !controlArr && (idx < hi_q);
        ram_addr   = controlArr ? controlArrAddr_a : idx[ADDR_W-1:0];
        any_valid  = s0_valid || s1_valid || s2_valid;
        hi_clamped = (init_hi > DEPTH_V) ? DEPTH_V : init_hi;
    end

    norm_accum_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (controlArr && controlArrWEnable_a),
        .addr  (ram_addr),
        .wdata (controlArrWData_a),
        .rdata (ram_rdata)
    );

    assign controlArrRData_a = ram_rdata;

    // Negating the most negative element yields 2^(DATA_W-1), which is exact as unsigned.
    always_comb begin
        abs_x = s1_data[DATA_W-1] ? DATA_W'(-s1_data) : DATA_W'(s1_data);
        sq_x  = {{DATA_W{1'b0}}, abs_x} * {{DATA_W{1'b0}}, abs_x};
        unique case (mode_q)
            SQ:      term = (ACC_W+1)'(sq_x);
            ABS:     term = (ACC_W+1)'(abs_x);
            SUM:     term = (ACC_W+1)'(s1_data);
            MAXABS:  term = (ACC_W+1)'(abs_x);
            default: term = '0;
        endcase
        acc_ext = $signed({acc[ACC_W-1], acc});
        sum_ext = acc_ext + s2_term;
        sat     = saturate(sum_ext[ACC_W], sum_ext[ACC_W-1]);
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            state    <= RUN;
            mode_q   <= mode_e'(init_mode);
            idx      <= {1'b0, init_lo};
            hi_q     <= hi_clamped;
            acc      <= init_acc;
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            w_enable <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            s0_valid <= issue;
            s1_valid <= s0_valid;
            s2_valid <= s1_valid;
            if (issue)
                idx <= idx + (ADDR_W+1)'(1);
            if (s0_valid)
                s1_data <= ram_rdata;
            if (s1_valid)
                s2_term <= term;

            if (s2_valid) begin
                if (mode_q == MAXABS) begin
                    if (s2_term > acc_ext)
                        acc <= s2_term[ACC_W-1:0];
                end else begin
                    unique case (sat)
                        SAT_MAX: begin
                            acc      <= ACC_MAX;
                            overflow <= 1'b1;
                        end
                        SAT_MIN: begin
                            acc      <= ACC_MIN;
                            overflow <= 1'b1;
                        end
                        default: acc <= sum_ext[ACC_W-1:0];
                    endcase
                end
            end

            // An empty range has nothing in flight, so RUN can finish directly.
            case (state)
                RUN: begin
                    if (idx >= hi_q) begin
                        if (!any_valid) begin
                            state    <= DONE;
                            w_enable <= 1'b1;
                            result   <= acc;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!any_valid) begin
                        state    <= DONE;
                        w_enable <= 1'b1;
                        result   <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
